id_ex_stage: RTL and testbench

- Decode-and-operand stage that sits directly downstream of the register file.
- Splits the IF/ID instruction and drives raddr1/raddr2 into the register file.
- Resolves operands from regfile read data plus EX/MEM forwarding, and detects load-use hazards.
- Latches a clean ID/EX pipeline register that feeds the ALU/EX stage.

---
 rtl/cpu_pkg.sv | 76 +++++++
 rtl/id_fwd_mux.sv | 30 +++
 rtl/id_ex_stage.sv | 155 +++++++++++++++
 tb/tb_id_ex_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the decode/operand stage: opcodes, default widths,
// the ID/EX control bundle and the instruction decoder.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Control fields carried through ID/EX; waddr travels with them so a
  // bubble never names a destination register.
  typedef struct packed {
    logic [REG_AW-1:0] waddr;
    logic              we;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jump;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef struct packed {
    ctrl_t ctrl;
    logic  uses_rs;
    logic  uses_rt;
  } decode_t;

  // Opcode decode; unknown opcodes fall through as a nop with no flags.
  function automatic decode_t decode(input logic [31:0] instr);
    decode_t d;
    d = '0;
    case (instr[31:26])
      OP_RTYPE: begin
        d.ctrl.we    = 1'b1;
        d.ctrl.waddr = instr[15:11];
        d.uses_rs    = 1'b1;
        d.uses_rt    = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.we    = 1'b1;
        d.ctrl.waddr = instr[20:16];
        d.uses_rs    = 1'b1;
      end
      OP_LW: begin
        d.ctrl.we       = 1'b1;
        d.ctrl.mem_read = 1'b1;
        d.ctrl.waddr    = instr[20:16];
        d.uses_rs       = 1'b1;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.uses_rs        = 1'b1;
        d.uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.uses_rs     = 1'b1;
        d.uses_rt     = 1'b1;
      end
      OP_J: begin
        d.ctrl.jump = 1'b1;
      end
      default: d = '0;
    endcase
    // Writes to $0 are architecturally discarded, so never advertise them.
    if (d.ctrl.waddr == '0) d.ctrl.we = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-operand forwarding mux: $0, then EX result, then MEM write data,
// then the register file value.
module id_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rdata,
  input  logic              ex_fwd_en,
  input  logic [REG_AW-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] data
);

  // Youngest producer wins; $0 always reads as zero whatever is in flight.
  always_comb begin
    data = rdata;
    if (addr == '0) begin
      data = '0;
    end else if (ex_fwd_en && ex_waddr == addr) begin
      data = ex_data;
    end else if (mem_we && mem_waddr == addr) begin
      data = mem_wdata;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-and-operand stage: drives regfile read addresses, resolves
// forwarded operands, detects load-use hazards and latches ID/EX.
module id_ex_stage #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_pc,
  output logic [REG_AW-1:0] raddr1,
  output logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [5:0]        ex_funct,
  output logic [REG_AW-1:0] ex_waddr,
  output logic              ex_we,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic [25:0]       ex_jtarget
);

  import cpu_pkg::*;

  decode_t           dec;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              ex_fwd_en;
  logic [REG_AW-1:0] src_addr  [2];
  logic [DATA_W-1:0] src_rdata [2];
  logic [DATA_W-1:0] src_fwd   [2];

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] pc_q,      pc_d;
  logic [DATA_W-1:0] op1_q,     op1_d;
  logic [DATA_W-1:0] op2_q,     op2_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [5:0]        funct_q,   funct_d;
  logic [25:0]       jtarget_q, jtarget_d;
  ctrl_t             ctrl_q,    ctrl_d;

  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign raddr1 = rs;
  assign raddr2 = rt;
  assign dec    = decode(id_instr);

  // A load in EX has no data yet, so it must not be forwarded from EX.
  assign ex_fwd_en = valid_q && ctrl_q.we && !ctrl_q.mem_read;

  assign src_addr[0]  = rs;
  assign src_addr[1]  = rt;
  assign src_rdata[0] = rdata1;
  assign src_rdata[1] = rdata2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      id_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
      ) u_fwd_mux (
        .addr      (src_addr[gi]),
        .rdata     (src_rdata[gi]),
        .ex_fwd_en (ex_fwd_en),
        .ex_waddr  (ctrl_q.waddr),
        .ex_data   (ex_alu_result),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .data      (src_fwd[gi])
      );
    end
  endgenerate

  // Load-use hazard: the ID instruction reads the register a load in EX is about to fetch.
  always_comb begin
    stall = id_valid && !flush && valid_q && ctrl_q.mem_read && (ctrl_q.waddr != '0) &&
            ((dec.uses_rs && ctrl_q.waddr == rs) || (dec.uses_rt && ctrl_q.waddr == rt));
  end

  // Next ID/EX contents: bubble on flush or stall, otherwise the decoded instruction.
  always_comb begin
    valid_d   = 1'b0;
    pc_d      = '0;
    op1_d     = '0;
    op2_d     = '0;
    imm_d     = '0;
    funct_d   = '0;
    jtarget_d = '0;
    ctrl_d    = CTRL_BUBBLE;
    if (!flush && !stall) begin
      valid_d   = id_valid;
      pc_d      = id_pc;
      op1_d     = src_fwd[0];
      op2_d     = src_fwd[1];
      imm_d     = {{(DATA_W-16){id_instr[15]}}, id_instr[15:0]};
      funct_d   = id_instr[5:0];
      jtarget_d = id_instr[25:0];
      ctrl_d    = id_valid ? dec.ctrl : CTRL_BUBBLE;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      funct_q   <= '0;
      jtarget_q <= '0;
      ctrl_q    <= CTRL_BUBBLE;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      imm_q     <= imm_d;
      funct_q   <= funct_d;
      jtarget_q <= jtarget_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_imm       = imm_q;
  assign ex_funct     = funct_q;
  assign ex_jtarget   = jtarget_q;
  assign ex_waddr     = ctrl_q.waddr;
  assign ex_we        = ctrl_q.we;
  assign ex_mem_read  = ctrl_q.mem_read;
  assign ex_mem_write = ctrl_q.mem_write;
  assign ex_branch    = ctrl_q.branch;
  assign ex_jump      = ctrl_q.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues the expected ID/EX
// contents for each edge, a monitor pops and compares after that edge.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] ex_alu_result;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [31:0] ex_imm;
  logic [5:0]  ex_funct;
  logic [4:0]  ex_waddr;
  logic        ex_we;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jump;
  logic [25:0] ex_jtarget;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [5:0]  funct;
    logic [4:0]  waddr;
    logic        we;
    logic        mr;
    logic        mw;
    logic        br;
    logic        jp;
    logic [25:0] jt;
  } idex_t;

  idex_t sb[$];
  int    errors = 0;
  int    checks = 0;
  int    txn    = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .raddr1        (raddr1),
    .raddr2        (raddr2),
    .rdata1        (rdata1),
    .rdata2        (rdata2),
    .ex_alu_result (ex_alu_result),
    .mem_we        (mem_we),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .flush         (flush),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .ex_pc         (ex_pc),
    .ex_op1        (ex_op1),
    .ex_op2        (ex_op2),
    .ex_imm        (ex_imm),
    .ex_funct      (ex_funct),
    .ex_waddr      (ex_waddr),
    .ex_we         (ex_we),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_jtarget    (ex_jtarget)
  );

  function automatic idex_t dut_state();
    return {ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_funct, ex_waddr,
            ex_we, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jtarget};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  // Valid ID/EX entry; funct and jump target are just the stimulus word's low bits.
  function automatic idex_t mk(input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] op1, input logic [31:0] op2,
                               input logic [31:0] imm, input logic [4:0] waddr,
                               input logic we, input logic mr, input logic mw,
                               input logic br, input logic jp);
    idex_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.op1   = op1;
    e.op2   = op2;
    e.imm   = imm;
    e.funct = instr[5:0];
    e.waddr = waddr;
    e.we    = we;
    e.mr    = mr;
    e.mw    = mw;
    e.br    = br;
    e.jp    = jp;
    e.jt    = instr[25:0];
    return e;
  endfunction

  localparam idex_t BUBBLE = '0;

  // Monitor: one scoreboard entry per clock edge while the driver is issuing.
  always @(posedge clk) begin
    idex_t got;
    idex_t exp_e;
    #1;
    if (sb.size() > 0) begin
      exp_e = sb.pop_front();
      got   = dut_state();
      checks++;
      txn++;
      if (got !== exp_e) begin
        errors++;
        $display("FAIL idex txn %0d: got=%h required=%h", txn, got, exp_e);
      end else begin
        $display("txn %0d idex ok: valid=%0b pc=%h op1=%h op2=%h imm=%h waddr=%0d we=%0b",
                 txn, got.valid, got.pc, got.op1, got.op2, got.imm, got.waddr, got.we);
      end
    end
  end

  task automatic set_in(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] alu,
                        input logic mwe, input logic [4:0] mwa, input logic [31:0] mwd,
                        input logic fl);
    id_valid      = v;
    id_instr      = instr;
    id_pc         = pc;
    rdata1        = rd1;
    rdata2        = rd2;
    ex_alu_result = alu;
    mem_we        = mwe;
    mem_waddr     = mwa;
    mem_wdata     = mwd;
    flush         = fl;
  endtask

  task automatic check_comb(input string name, input logic exp_stall);
    logic [10:0] got_c;
    logic [10:0] exp_c;
    got_c = {stall, raddr1, raddr2};
    exp_c = {exp_stall, id_instr[25:21], id_instr[20:16]};
    checks++;
    if (got_c !== exp_c) begin
      errors++;
      $display("FAIL %s stall/raddr: got=%h required=%h", name, got_c, exp_c);
    end
  endtask

  // Drive one ID cycle from a negedge, check stall/raddr, queue the ID/EX result.
  task automatic step(input string name, input logic v, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] rd1, input logic [31:0] rd2,
                      input logic [31:0] alu, input logic mwe, input logic [4:0] mwa,
                      input logic [31:0] mwd, input logic fl, input logic exp_stall,
                      input idex_t exp_e);
    set_in(v, instr, pc, rd1, rd2, alu, mwe, mwa, mwd, fl);
    #1;
    check_comb(name, exp_stall);
    sb.push_back(exp_e);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string name);
    idex_t got;
    got = dut_state();
    checks++;
    if (got !== BUBBLE || stall !== 1'b0) begin
      errors++;
      $display("FAIL %s: got state=%h stall=%b required all zero", name, got, stall);
    end else begin
      $display("%s: outputs cleared", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] i_addi2, i_lw5, i_add6, i_add3, i_sub7, i_addi4, i_add8, i_add9;
    logic [31:0] i_lw5b, i_add0, i_sw, i_beq, i_j, i_nop, i_lw10, i_sw10, i_addi1;
    int wait_cycles;

    i_addi2 = itype(6'b001000, 5'd0, 5'd2, 16'd7);
    i_lw5   = itype(6'b100011, 5'd0, 5'd5, 16'd0);
    i_add6  = rtype(5'd5, 5'd1, 5'd6, 6'h20);
    i_add3  = rtype(5'd1, 5'd2, 5'd3, 6'h20);
    i_sub7  = rtype(5'd3, 5'd0, 5'd7, 6'h22);
    i_addi4 = itype(6'b001000, 5'd0, 5'd4, 16'd1);
    i_add8  = rtype(5'd1, 5'd4, 5'd8, 6'h20);
    i_add9  = rtype(5'd1, 5'd4, 5'd9, 6'h20);
    i_lw5b  = itype(6'b100011, 5'd9, 5'd5, 16'd4);
    i_add0  = rtype(5'd0, 5'd0, 5'd0, 6'h20);
    i_sw    = itype(6'b101011, 5'd3, 5'd2, 16'hFFFC);
    i_beq   = itype(6'b000100, 5'd1, 5'd2, 16'hFFFF);
    i_j     = jtype(26'h3FFFFFF);
    i_nop   = 32'hFC00_0000;
    i_lw10  = itype(6'b100011, 5'd0, 5'd10, 16'd0);
    i_sw10  = itype(6'b101011, 5'd0, 5'd10, 16'd0);
    i_addi1 = itype(6'b001000, 5'd0, 5'd1, 16'd5);

    rst = 1'b1;
    set_in(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check_reset_state("reset_initial");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step("addi2", 1, i_addi2, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_addi2, 32'h100, 0, 0, 32'd7, 5'd2, 1, 0, 0, 0, 0));
    step("lw5", 1, i_lw5, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_lw5, 32'h104, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0));
    step("loaduse_stall", 1, i_add6, 32'h108, 0, 32'h10, 0, 0, 0, 0, 0, 1, BUBBLE);
    step("loaduse_retry", 1, i_add6, 32'h108, 0, 32'h10, 0, 1, 5'd5, 32'h44, 0, 0,
         mk(i_add6, 32'h108, 32'h44, 32'h10, 32'h3020, 5'd6, 1, 0, 0, 0, 0));
    step("add3", 1, i_add3, 32'h10C, 1, 2, 0, 0, 0, 0, 0, 0,
         mk(i_add3, 32'h10C, 1, 2, 32'h1820, 5'd3, 1, 0, 0, 0, 0));
    step("ex_fwd", 1, i_sub7, 32'h110, 32'h99, 0, 32'h11, 0, 0, 0, 0, 0,
         mk(i_sub7, 32'h110, 32'h11, 0, 32'h3822, 5'd7, 1, 0, 0, 0, 0));
    step("addi4", 1, i_addi4, 32'h114, 0, 0, 32'h5A, 0, 0, 0, 0, 0,
         mk(i_addi4, 32'h114, 0, 0, 32'd1, 5'd4, 1, 0, 0, 0, 0));
    step("ex_over_mem", 1, i_add8, 32'h118, 3, 32'h55, 32'h33, 1, 5'd4, 32'h22, 0, 0,
         mk(i_add8, 32'h118, 3, 32'h33, 32'h4020, 5'd8, 1, 0, 0, 0, 0));
    step("mem_fwd", 1, i_add9, 32'h11C, 3, 32'h55, 32'h77, 1, 5'd4, 32'h22, 0, 0,
         mk(i_add9, 32'h11C, 3, 32'h22, 32'h4820, 5'd9, 1, 0, 0, 0, 0));
    step("lw5_fwd_rs", 1, i_lw5b, 32'h120, 0, 0, 32'h60, 0, 0, 0, 0, 0,
         mk(i_lw5b, 32'h120, 32'h60, 0, 32'd4, 5'd5, 1, 1, 0, 0, 0));
    step("flush_over_stall", 1, i_add6, 32'h124, 7, 8, 32'h9, 0, 0, 0, 1, 0, BUBBLE);
    step("zero_reg", 1, i_add0, 32'h128, 32'hAB, 32'hAB, 32'hEE, 1, 5'd0, 32'hFF, 0, 0,
         mk(i_add0, 32'h128, 0, 0, 32'h20, 5'd0, 0, 0, 0, 0, 0));
    step("sw_negimm", 1, i_sw, 32'h12C, 32'h1000, 2, 0, 0, 0, 0, 0, 0,
         mk(i_sw, 32'h12C, 32'h1000, 2, 32'hFFFF_FFFC, 5'd0, 0, 0, 1, 0, 0));
    step("beq", 1, i_beq, 32'h130, 1, 2, 0, 0, 0, 0, 0, 0,
         mk(i_beq, 32'h130, 1, 2, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 1, 0));
    step("jump", 1, i_j, 32'h134, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_j, 32'h134, 0, 0, 32'hFFFF_FFFF, 5'd0, 0, 0, 0, 0, 1));
    step("unknown_op", 1, i_nop, 32'h138, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_nop, 32'h138, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0));
    step("lw10", 1, i_lw10, 32'h13C, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_lw10, 32'h13C, 0, 0, 0, 5'd10, 1, 1, 0, 0, 0));
    step("sw_rt_stall", 1, i_sw10, 32'h140, 0, 0, 0, 0, 0, 0, 0, 1, BUBBLE);
    step("sw_rt_retry", 1, i_sw10, 32'h140, 0, 0, 0, 1, 5'd10, 32'h66, 0, 0,
         mk(i_sw10, 32'h140, 0, 32'h66, 0, 5'd0, 0, 0, 1, 0, 0));
    step("lw5_again", 1, i_lw5, 32'h144, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_lw5, 32'h144, 0, 0, 0, 5'd5, 1, 1, 0, 0, 0));

    // Load-use hazard pending, then reset lands mid-cycle.
    set_in(1'b1, i_add6, 32'h148, 0, 0, 0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    check_comb("midstall_pre", 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_state("reset_midstall");
    @(negedge clk);
    rst = 1'b0;

    step("addi1_after_rst", 1, i_addi1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0,
         mk(i_addi1, 32'h200, 0, 0, 32'd5, 5'd1, 1, 0, 0, 0, 0));
    step("idle", 0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, BUBBLE);

    wait_cycles = 0;
    while (sb.size() != 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, required 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
